// File: rtl/usart_pkg.sv
// Shared types and helpers for the USART transmit/receive control blocks.
// Optional feature macro: USART_TX_BREAK_EN adds the BREAK state.
package usart_pkg;

    // Frame sequencer states; encodings stay the same with or without BREAK.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
`ifdef USART_TX_BREAK_EN
        ST_STOP2  = 3'd5,
        ST_BREAK  = 3'd6
`else
        ST_STOP2  = 3'd5
`endif
    } tx_state_e;

    // Character size codes (UCSZ2:0).
    localparam logic [2:0] UCSZ_5 = 3'b000;
    localparam logic [2:0] UCSZ_6 = 3'b001;
    localparam logic [2:0] UCSZ_7 = 3'b010;
    localparam logic [2:0] UCSZ_8 = 3'b011;
    localparam logic [2:0] UCSZ_9 = 3'b111;

    // Number of data bits in a frame; reserved codes behave as 8-bit characters.
    function automatic logic [3:0] ucsz_to_nbits(input logic [2:0] ucsz);
        logic [3:0] nbits;
        case (ucsz)
            UCSZ_5:  nbits = 4'd5;
            UCSZ_6:  nbits = 4'd6;
            UCSZ_7:  nbits = 4'd7;
            UCSZ_9:  nbits = 4'd9;
            default: nbits = 4'd8;
        endcase
        return nbits;
    endfunction

endpackage

// File: rtl/usart_tx_fsm_if.sv
// Control/status bundle between the transmitter FSM and its surroundings.
// slave  = the FSM side, master = the data path / register side.
// Handshake: the FSM never waits on a ready; it consumes i_udre (0 = data pending)
// at each i_txclk tick and releases UDR by asserting o_fsm_we in START, which the
// data path samples on that same tick.
// Optional feature macro: USART_TX_BREAK_EN adds i_break.
interface usart_tx_fsm_if #(parameter int CNT_W = 4);
    logic             i_txclk;
    logic             i_txen;
    logic             i_udre;
    logic [2:0]       i_UCSZ;
    logic             i_UPM1;
    logic             i_USBS;
`ifdef USART_TX_BREAK_EN
    logic             i_break;
`endif
    logic             o_fsm_we;
    logic             o_fsm_ps;
    logic             o_fsm_ad;
    logic             o_fsm_pi;
    logic             o_fsm_dp;
    logic             o_txc;
    logic             o_busy;
    logic [2:0]       dbg_state;
    logic [CNT_W-1:0] dbg_cnt;

    modport slave (
        input  i_txclk, i_txen, i_udre, i_UCSZ, i_UPM1, i_USBS,
`ifdef USART_TX_BREAK_EN
        input  i_break,
`endif
        output o_fsm_we, o_fsm_ps, o_fsm_ad, o_fsm_pi, o_fsm_dp,
        output o_txc, o_busy, dbg_state, dbg_cnt
    );

    modport master (
        output i_txclk, i_txen, i_udre, i_UCSZ, i_UPM1, i_USBS,
`ifdef USART_TX_BREAK_EN
        output i_break,
`endif
        input  o_fsm_we, o_fsm_ps, o_fsm_ad, o_fsm_pi, o_fsm_dp,
        input  o_txc, o_busy, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/usart_bit_counter.sv
// Data-bit counter with synchronous clear, count enable and terminal-count compare.
// Shared by the transmitter and receiver sequencers.
module usart_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_tc  = (cnt_q == i_term);
endmodule

// File: rtl/usart_tx_fsm.sv
// USART transmitter control FSM: sequences start, 5-9 data bits, optional parity
// and 1-2 stop bits, one frame bit per i_txclk tick, by driving the data path
// selects as Moore decodes of the current state.
// Optional feature macro: USART_TX_BREAK_EN (line-break generation).
module usart_tx_fsm
    import usart_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter bit IDLE_LVL = 1'b1
) (
    input  logic                 i_fosk,
    input  logic                 i_rst,
    usart_tx_fsm_if.slave        bus
);
    tx_state_e        state_q, state_d;
    logic [3:0]       cfg_nbits_q;
    logic             cfg_upm1_q;
    logic             cfg_usbs_q;
    logic             load_cfg;
    logic             clr_usbs;
    logic             txc_q, txc_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt_term;
    logic             pending;

    assign pending  = bus.i_txen && !bus.i_udre;
    assign cnt_term = CNT_W'(cfg_nbits_q - 4'd1);

    usart_bit_counter #(.CNT_W(CNT_W)) u_bit_cnt (
        .i_clk  (i_fosk),
        .i_rst  (i_rst),
        .i_clr  (cnt_clr),
        .i_en   (cnt_en),
        .i_term (cnt_term),
        .o_cnt  (cnt_val),
        .o_tc   (cnt_tc)
    );

    // Next-state logic; nothing moves except on a bit-rate tick.
    always_comb begin
        state_d  = state_q;
        load_cfg = 1'b0;
        clr_usbs = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        txc_d    = 1'b0;
        if (bus.i_txclk) begin
            case (state_q)
                ST_IDLE: begin
`ifdef USART_TX_BREAK_EN
                    if (bus.i_break) begin
                        state_d = ST_BREAK;
                    end else
`endif
                    if (pending) begin
                        state_d  = ST_START;
                        load_cfg = 1'b1;
                    end
                end
                ST_START: begin
                    state_d = ST_DATA;
                    cnt_clr = 1'b1;
                end
                ST_DATA: begin
                    if (cnt_tc) begin
                        state_d = cfg_upm1_q ? ST_PARITY : ST_STOP1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_PARITY: state_d = ST_STOP1;
                ST_STOP1: begin
                    if (cfg_usbs_q) begin
                        state_d = ST_STOP2;
                    end else if (pending) begin
                        state_d  = ST_START;
                        load_cfg = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        txc_d   = 1'b1;
                    end
                end
                ST_STOP2: begin
                    if (pending) begin
                        state_d  = ST_START;
                        load_cfg = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        txc_d   = 1'b1;
                    end
                end
`ifdef USART_TX_BREAK_EN
                ST_BREAK: begin
                    // A break is always closed with a single stop bit.
                    if (!bus.i_break) begin
                        state_d  = ST_STOP1;
                        clr_usbs = 1'b1;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and transmit-complete registers.
    always_ff @(posedge i_fosk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            txc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            txc_q   <= txc_d;
        end
    end

    // Frame configuration is frozen at each START so mid-frame writes cannot corrupt a frame.
    always_ff @(posedge i_fosk or posedge i_rst) begin
        if (i_rst) begin
            cfg_nbits_q <= 4'd5;
            cfg_upm1_q  <= 1'b0;
            cfg_usbs_q  <= 1'b0;
        end else if (load_cfg) begin
            cfg_nbits_q <= ucsz_to_nbits(bus.i_UCSZ);
            cfg_upm1_q  <= bus.i_UPM1;
            cfg_usbs_q  <= bus.i_USBS;
        end else if (clr_usbs) begin
            cfg_usbs_q  <= 1'b0;
        end
    end

    // Moore decode of the data path selects (we, ps, ad, pi, dp).
    always_comb begin
        bus.o_fsm_we = 1'b0;
        bus.o_fsm_ps = IDLE_LVL;
        bus.o_fsm_ad = 1'b0;
        bus.o_fsm_pi = 1'b0;
        bus.o_fsm_dp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.o_fsm_pi = 1'b1;
            end
            ST_START: begin
                bus.o_fsm_we = 1'b1;
                bus.o_fsm_ps = 1'b0;
                bus.o_fsm_pi = 1'b1;
            end
            ST_DATA: begin
                bus.o_fsm_ad = 1'b1;
            end
            ST_PARITY: begin
                bus.o_fsm_ps = 1'b1;
                bus.o_fsm_dp = 1'b1;
            end
            ST_STOP1, ST_STOP2: begin
                bus.o_fsm_ps = 1'b1;
            end
`ifdef USART_TX_BREAK_EN
            ST_BREAK: begin
                bus.o_fsm_ps = 1'b0;
                bus.o_fsm_pi = 1'b1;
            end
`endif
            default: begin
                bus.o_fsm_pi = 1'b1;
            end
        endcase
    end

    assign bus.o_txc     = txc_q;
    assign bus.o_busy    = (state_q != ST_IDLE);
    assign bus.dbg_state = state_q;
    assign bus.dbg_cnt   = cnt_val;
endmodule

// File: tb/tb_usart_tx_fsm.sv
// Bench for usart_tx_fsm: a behavioural transmitter data path turns the FSM selects
// into a TxD bit stream; expected frame bits are queued per frame and compared by
// a monitor on every busy tick.
module tb_usart_tx_fsm;
    import usart_pkg::*;

    logic i_fosk = 1'b0;
    logic i_rst  = 1'b1;

    usart_tx_fsm_if #(.CNT_W(4)) bus();

    usart_tx_fsm #(.CNT_W(4), .IDLE_LVL(1'b1)) dut (
        .i_fosk (i_fosk),
        .i_rst  (i_rst),
        .bus    (bus)
    );

    // Clock: 10 time units, tick every 4th cycle.
    always #5 i_fosk = ~i_fosk;

    logic [1:0] div_q   = 2'd0;
    logic       txclk_q = 1'b0;
    always @(posedge i_fosk) begin
        div_q   <= div_q + 2'd1;
        txclk_q <= (div_q == 2'd2);
    end
    assign bus.i_txclk = txclk_q;

    // Data path model: UDR, shift register, parity, TxD.
    logic [8:0] udr_q = '0, sh_q = '0, wr_data = '0;
    logic       udre_q = 1'b1, par_q = 1'b0, txd_q = 1'b1;
    logic       busy_tick_q = 1'b0, tick_q = 1'b0, wr_req = 1'b0, upm0 = 1'b0;
    assign bus.i_udre = udre_q;

    always @(posedge i_fosk) begin
        tick_q      <= txclk_q;
        busy_tick_q <= txclk_q && bus.o_busy;
        if (wr_req) begin
            udr_q  <= wr_data;
            udre_q <= 1'b0;
        end else if (txclk_q && bus.o_fsm_we) begin
            udre_q <= 1'b1;
        end
        if (txclk_q) begin
            if (bus.o_fsm_we) sh_q <= udr_q;
            if (bus.o_fsm_ad) begin
                txd_q <= sh_q[0];
                par_q <= par_q ^ sh_q[0];
                sh_q  <= sh_q >> 1;
            end else if (bus.o_fsm_dp) begin
                txd_q <= par_q;
            end else begin
                txd_q <= bus.o_fsm_ps;
            end
            if (bus.o_fsm_pi) par_q <= upm0;
        end
    end

    // Scoreboard state.
    logic exp_q[$];
    int   n_checks = 0, n_errors = 0;
    int   busy_ticks = 0, txc_cycles = 0, tick_base = 0, txc_base = 0;
    logic mon_en = 1'b1;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every tick taken in a non-idle state produces one TxD bit.
    always @(negedge i_fosk) begin
        if (busy_tick_q) begin
            busy_ticks++;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 16'(txd_q), 16'hffff);
                end else begin
                    check("txd_bit", 16'(txd_q), 16'(exp_q.pop_front()));
                end
            end
        end
        if (bus.o_txc) txc_cycles++;
    end

    task automatic wait_tick();
        @(negedge i_fosk);
        while (!tick_q) @(negedge i_fosk);
    endtask

    task automatic write_udr(input logic [8:0] d);
        @(negedge i_fosk);
        wr_data = d;
        wr_req  = 1'b1;
        @(negedge i_fosk);
        wr_req  = 1'b0;
    endtask

    task automatic push_frame(input int nbits, input logic upm1, input logic odd,
                              input logic usbs, input logic [8:0] d);
        logic p;
        p = odd;
        exp_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (upm1) exp_q.push_back(p);
        exp_q.push_back(1'b1);
        if (usbs) exp_q.push_back(1'b1);
    endtask

    task automatic start_scn();
        tick_base = busy_ticks;
        txc_base  = txc_cycles;
    endtask

    task automatic wait_loaded(input string name);
        int i;
        for (i = 0; i < 500 && !(bus.o_busy && bus.i_udre); i++) @(negedge i_fosk);
        check({name, "_load_timeout"}, 16'(i < 500), 16'd1);
    endtask

    task automatic wait_done(input string name, input int exp_txc, input int exp_ticks);
        int i;
        for (i = 0; i < 3000 && (exp_q.size() != 0 || bus.o_busy); i++) @(negedge i_fosk);
        check({name, "_timeout"}, 16'(i < 3000), 16'd1);
        repeat (4) @(negedge i_fosk);
        check({name, "_txc_cycles"}, 16'(txc_cycles - txc_base), 16'(exp_txc));
        check({name, "_frame_ticks"}, 16'(busy_ticks - tick_base), 16'(exp_ticks));
        check({name, "_busy_end"}, 16'(bus.o_busy), 16'd0);
        check({name, "_queue_left"}, 16'(exp_q.size()), 16'd0);
    endtask

    task automatic set_cfg(input logic [2:0] ucsz, input logic upm1, input logic odd, input logic usbs);
        bus.i_UCSZ = ucsz;
        bus.i_UPM1 = upm1;
        upm0       = odd;
        bus.i_USBS = usbs;
    endtask

    initial begin
        bus.i_txen = 1'b0;
        set_cfg(3'b011, 1'b0, 1'b0, 1'b0);
`ifdef USART_TX_BREAK_EN
        bus.i_break = 1'b0;
`endif
        // Reset state.
        repeat (3) @(negedge i_fosk);
        check("rst_we",    16'(bus.o_fsm_we), 16'd0);
        check("rst_ps",    16'(bus.o_fsm_ps), 16'd1);
        check("rst_ad",    16'(bus.o_fsm_ad), 16'd0);
        check("rst_pi",    16'(bus.o_fsm_pi), 16'd1);
        check("rst_dp",    16'(bus.o_fsm_dp), 16'd0);
        check("rst_busy",  16'(bus.o_busy),   16'd0);
        check("rst_txc",   16'(bus.o_txc),    16'd0);
        check("rst_state", 16'(bus.dbg_state), 16'(ST_IDLE));
        i_rst = 1'b0;
        wait_tick();
        wait_tick();
        check("idle_txd", 16'(txd_q), 16'd1);
        bus.i_txen = 1'b1;

        // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1.
        start_scn();
        set_cfg(3'b011, 1'b0, 1'b0, 1'b0);
        push_frame(8, 1'b0, 1'b0, 1'b0, 9'h0A5);
        write_udr(9'h0A5);
        wait_done("f8n1", 1, 10);

        // 7O2, 0x55, config rewritten mid-frame must not matter: 11 ticks.
        start_scn();
        set_cfg(3'b010, 1'b1, 1'b1, 1'b1);
        push_frame(7, 1'b1, 1'b1, 1'b1, 9'h055);
        write_udr(9'h055);
        wait_loaded("f7o2");
        set_cfg(3'b011, 1'b0, 1'b1, 1'b0);
        wait_done("f7o2", 1, 11);

`ifdef USART_TX_BREAK_EN
        // Break for 15 ticks, closed by one stop bit even though two were last latched.
        start_scn();
        for (int i = 0; i < 15; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        @(negedge i_fosk);
        bus.i_break = 1'b1;
        for (int i = 0; i < 15; i++) wait_tick();
        bus.i_break = 1'b0;
        wait_done("brk", 1, 16);
`endif

        // 9N1, tx8=1 data 0xFF: start, nine ones, stop.
        start_scn();
        set_cfg(3'b111, 1'b0, 1'b0, 1'b0);
        push_frame(9, 1'b0, 1'b0, 1'b0, 9'h1FF);
        write_udr(9'h1FF);
        wait_done("f9n1", 1, 11);

        // Back-to-back: second byte written during the first frame, single o_txc.
        start_scn();
        set_cfg(3'b011, 1'b0, 1'b0, 1'b0);
        push_frame(8, 1'b0, 1'b0, 1'b0, 9'h0A5);
        push_frame(8, 1'b0, 1'b0, 1'b0, 9'h03C);
        write_udr(9'h0A5);
        wait_loaded("b2b");
        write_udr(9'h03C);
        wait_done("b2b", 1, 20);

        // Transmitter disabled mid-frame: frame finishes, pending byte waits.
        start_scn();
        push_frame(8, 1'b0, 1'b0, 1'b0, 9'h00F);
        write_udr(9'h00F);
        wait_loaded("txen");
        write_udr(9'h0F0);
        wait_tick();
        bus.i_txen = 1'b0;
        wait_done("txen_off", 1, 10);
        repeat (3) wait_tick();
        check("txen_off_idle", 16'(bus.o_busy), 16'd0);
        check("txen_off_pending", 16'(bus.i_udre), 16'd0);
        start_scn();
        push_frame(8, 1'b0, 1'b0, 1'b0, 9'h0F0);
        bus.i_txen = 1'b1;
        wait_done("txen_on", 1, 10);

        // Asynchronous reset in the middle of DATA.
        mon_en = 1'b0;
        start_scn();
        write_udr(9'h0C3);
        begin
            int i;
            for (i = 0; i < 500 && bus.dbg_state != 3'(ST_DATA); i++) @(negedge i_fosk);
            check("mid_rst_reach_data", 16'(i < 500), 16'd1);
        end
        wait_tick();
        wait_tick();
        #2 i_rst = 1'b1;
        #1;
        check("mid_rst_we",   16'(bus.o_fsm_we), 16'd0);
        check("mid_rst_ps",   16'(bus.o_fsm_ps), 16'd1);
        check("mid_rst_ad",   16'(bus.o_fsm_ad), 16'd0);
        check("mid_rst_pi",   16'(bus.o_fsm_pi), 16'd1);
        check("mid_rst_dp",   16'(bus.o_fsm_dp), 16'd0);
        check("mid_rst_busy", 16'(bus.o_busy),   16'd0);
        @(negedge i_fosk);
        i_rst = 1'b0;
        wait_tick();
        check("mid_rst_txd", 16'(txd_q), 16'd1);
        repeat (40) @(negedge i_fosk);
        check("mid_rst_no_txc", 16'(txc_cycles - txc_base), 16'd0);
        check("mid_rst_stay_idle", 16'(bus.o_busy), 16'd0);
        mon_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
